// File: rtl/lcd_frame_writer.sv
// lcd_frame_writer: HD44780-compatible (8-bit, write-only) driver for a
// ROWS x COLS character panel. Runs the init command sequence after reset,
// then writes the whole frame from a snapshot of iFRAME, so the panel never
// shows a mix of two frames.
// Every byte takes SETUP (1 cycle), PULSE (EN high for EN_PULSE_CYC cycles)
// and SETTLE (EN low for SETTLE_CYC cycles).
// Optional: define AUTO_REFRESH_EN to start a frame whenever iFRAME differs
// from the last snapshot while idle.
module lcd_frame_writer #(
   parameter int COLS         = 16,
   parameter int ROWS         = 2,
   parameter int EN_PULSE_CYC = 16,
   parameter int SETTLE_CYC   = 262143
) (
   input  logic                   iCLK,
   input  logic                   iRST_N,
   input  logic [8*ROWS*COLS-1:0] iFRAME,
   input  logic                   iRefresh,
   output logic                   oBusy,
   output logic                   oFrameDone,
   output logic                   oInitDone,
   output logic [7:0]             LCD_DATA,
   output logic                   LCD_RW,
   output logic                   LCD_EN,
   output logic                   LCD_RS
);
   localparam int NCELL = ROWS * COLS;
   localparam int CMAX  = (EN_PULSE_CYC > SETTLE_CYC) ? EN_PULSE_CYC : SETTLE_CYC;
   localparam int CW    = $clog2(CMAX + 1);
   localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int COLW  = $clog2(COLS + 1);
   localparam int CELLW = (NCELL > 1) ? $clog2(NCELL) : 1;

   localparam logic [CW-1:0]   EN_LAST  = CW'(EN_PULSE_CYC - 1);
   localparam logic [CW-1:0]   SET_LAST = CW'(SETTLE_CYC - 1);
   localparam logic [RW-1:0]   ROW_LAST = RW'(ROWS - 1);
   localparam logic [COLW-1:0] COL_LAST = COLW'(COLS);

   typedef enum logic [1:0] {ST_INIT, ST_FRAME, ST_IDLE} state_t;
   // PH_START is the parked phase: the cycle after reset and every idle cycle
   typedef enum logic [1:0] {PH_START, PH_SETUP, PH_PULSE, PH_SETTLE} phase_t;

   state_t             state_q, state_d;
   phase_t             phase_q, phase_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [1:0]         init_q, init_d;
   logic [RW-1:0]      row_q, row_d;
   // col 0 is the set-address command of a row, cols 1..COLS are characters
   logic [COLW-1:0]    col_q, col_d;
   logic [CELLW-1:0]   cell_q, cell_d;
   logic [8*NCELL-1:0] snap_q, snap_d;
   logic               pend_q, pend_d;
   logic               fdone_q, fdone_d;
   logic               idone_q, idone_d;
   logic [7:0]         data_q;
   logic               rs_q;
   logic               load, enter, auto_req;
   logic [7:0]         nxt_data;
   logic               nxt_rs;
   logic [7:0]         cell_chr [NCELL];

   // cell 0 sits in the MSBs of the flat frame
   for (genvar g = 0; g < NCELL; g++) begin : g_cell
      assign cell_chr[g] = snap_q[8*(NCELL-g)-1 -: 8];
   end

`ifdef AUTO_REFRESH_EN
   assign auto_req = (iFRAME != snap_q);
`else
   assign auto_req = 1'b0;
`endif

   function automatic logic [7:0] row_off(input logic [RW-1:0] r);
      logic [7:0] o;
      case (int'(r))
         0:       o = 8'h00;
         1:       o = 8'h40;
         2:       o = 8'(COLS);
         default: o = 8'(64 + COLS);
      endcase
      return o;
   endfunction

   // next-state: byte phase timing, byte sequencing, frame entry and pending
   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      cnt_d   = cnt_q;
      init_d  = init_q;
      row_d   = row_q;
      col_d   = col_q;
      cell_d  = cell_q;
      snap_d  = snap_q;
      pend_d  = pend_q;
      fdone_d = 1'b0;
      idone_d = idone_q;
      load    = 1'b0;
      enter   = 1'b0;
      if (iRefresh && state_q != ST_IDLE) pend_d = 1'b1;
      unique case (phase_q)
         PH_START: begin
            if (state_q == ST_INIT) begin
               phase_d = PH_SETUP;
               load    = 1'b1;
            end else if (iRefresh || auto_req) begin
               enter = 1'b1;
            end
         end
         PH_SETUP: begin
            phase_d = PH_PULSE;
            cnt_d   = '0;
         end
         PH_PULSE: begin
            if (cnt_q == EN_LAST) begin
               phase_d = PH_SETTLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         PH_SETTLE: begin
            if (cnt_q != SET_LAST) begin
               cnt_d = cnt_q + 1'b1;
            end else if (state_q == ST_INIT) begin
               if (init_q == 2'd3) begin
                  idone_d = 1'b1;
                  enter   = 1'b1;
               end else begin
                  init_d  = init_q + 2'd1;
                  phase_d = PH_SETUP;
                  load    = 1'b1;
               end
            end else if (row_q == ROW_LAST && col_q == COL_LAST) begin
               fdone_d = 1'b1;
               // a request seen in this very cycle still counts as pending
               if (pend_q || iRefresh) begin
                  enter = 1'b1;
               end else begin
                  state_d = ST_IDLE;
                  phase_d = PH_START;
               end
            end else begin
               phase_d = PH_SETUP;
               load    = 1'b1;
               if (col_q != '0) cell_d = cell_q + 1'b1;
               if (col_q == COL_LAST) begin
                  col_d = '0;
                  row_d = row_q + 1'b1;
               end else begin
                  col_d = col_q + 1'b1;
               end
            end
         end
         default: ;
      endcase
      // frame entry satisfies any request made so far
      if (enter) begin
         state_d = ST_FRAME;
         phase_d = PH_SETUP;
         load    = 1'b1;
         row_d   = '0;
         col_d   = '0;
         cell_d  = '0;
         snap_d  = iFRAME;
         pend_d  = 1'b0;
      end
   end

   // byte to put on the bus when the next SETUP begins
   always_comb begin
      nxt_data = 8'h00;
      nxt_rs   = 1'b0;
      if (state_d == ST_INIT) begin
         case (init_d)
            2'd0:    nxt_data = 8'h38;
            2'd1:    nxt_data = 8'h0C;
            2'd2:    nxt_data = 8'h01;
            default: nxt_data = 8'h06;
         endcase
      end else if (col_d == '0) begin
         nxt_data = 8'h80 | row_off(row_d);
      end else begin
         nxt_data = cell_chr[cell_d];
         nxt_rs   = 1'b1;
      end
   end

   // state and datapath registers; bus value only changes at byte start
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state_q <= ST_INIT;
         phase_q <= PH_START;
         cnt_q   <= '0;
         init_q  <= '0;
         row_q   <= '0;
         col_q   <= '0;
         cell_q  <= '0;
         snap_q  <= '0;
         pend_q  <= 1'b0;
         fdone_q <= 1'b0;
         idone_q <= 1'b0;
         data_q  <= 8'h00;
         rs_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         cnt_q   <= cnt_d;
         init_q  <= init_d;
         row_q   <= row_d;
         col_q   <= col_d;
         cell_q  <= cell_d;
         snap_q  <= snap_d;
         pend_q  <= pend_d;
         fdone_q <= fdone_d;
         idone_q <= idone_d;
         if (load) begin
            data_q <= nxt_data;
            rs_q   <= nxt_rs;
         end
      end
   end

   assign LCD_EN     = (phase_q == PH_PULSE);
   assign LCD_DATA   = data_q;
   assign LCD_RS     = rs_q;
   assign LCD_RW     = 1'b0;
   assign oBusy      = (state_q != ST_IDLE);
   assign oFrameDone = fdone_q;
   assign oInitDone  = idone_q;

endmodule
